// File: rtl/counter_push_ctrl.sv
// counter_push_ctrl
// Front-end controller for the 4-bit LED up/down counter. The two raw
// active-low push buttons are synchronised, debounced and edge-detected.
// Simultaneous presses are arbitrated, the count limits are enforced against
// the counter's current value, and single-cycle Up_o/Dn_o enables are issued.
//
// Optional feature: define COUNTER_PUSH_CTRL_AUTOREPEAT_EN to enable
// hold-to-repeat. The RPT_DELAY/RPT_RATE parameters only exist in that build.
// Push[1] is the up button and Push[0] is the down button.
// A debounced level of 0 means the button is held.

module counter_push_ctrl #(
  parameter int CNT_W      = 4,
  parameter int CNT_MAX    = 15,
  parameter int CNT_MIN    = 0,
  parameter int DEB_CYCLES = 4
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
  ,
  parameter int RPT_DELAY  = 16,
  parameter int RPT_RATE   = 8
`endif
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       Push,
  input  logic [CNT_W-1:0] Cnt_i,
  output logic             Up_o,
  output logic             Dn_o,
  output logic             Blocked_o,
  output logic [1:0]       State_o
);

  localparam int               DEB_W    = $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(CNT_MIN);

`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
  localparam int               RPT_MAXV = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int               RPT_W    = $clog2(RPT_MAXV + 1);
  localparam logic [RPT_W-1:0] RPT_DLY  = RPT_W'(RPT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PER  = RPT_W'(RPT_RATE);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD_UP = 2'd1,
    HOLD_DN = 2'd2,
    LOCK    = 2'd3
  } state_e;

  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       debLvl_q;
  logic [1:0]       debLvl_d;
  logic [DEB_W-1:0] debCnt_q [2];
  logic [DEB_W-1:0] debCnt_d [2];
  logic [1:0]       debPrev_q;
  logic [1:0]       press;
  logic             atMax;
  logic             atMin;
  state_e           state_q;

`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
  logic [RPT_W-1:0] rptCnt_q;
  logic             rptFirst_q;
  logic             rptMute_q;
  logic             rptFire;
`endif

  // Two-flop synchroniser per button; reset to the released level.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= Push;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: accept a new level after DEB_CYCLES consecutive differing samples.
  always_comb begin
    debLvl_d = debLvl_q;
    for (int i = 0; i < 2; i++) begin
      debCnt_d[i] = '0;
      if (sync2_q[i] != debLvl_q[i]) begin
        if (debCnt_q[i] == DEB_LAST) begin
          debLvl_d[i] = sync2_q[i];
        end else begin
          debCnt_d[i] = debCnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce registers plus the previous debounced level used for edge detection.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      debLvl_q    <= 2'b11;
      debPrev_q   <= 2'b11;
      debCnt_q[0] <= '0;
      debCnt_q[1] <= '0;
    end else begin
      debLvl_q    <= debLvl_d;
      debPrev_q   <= debLvl_q;
      debCnt_q[0] <= debCnt_d[0];
      debCnt_q[1] <= debCnt_d[1];
    end
  end

  // A press is a falling edge of the debounced level; limits use the live counter value.
  always_comb begin
    press = debPrev_q & ~debLvl_q;
    atMax = (Cnt_i == CNT_HI);
    atMin = (Cnt_i == CNT_LO);
  end

`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
  // The first repeat waits RPT_DELAY cycles after the initial pulse; later ones wait RPT_RATE.
  always_comb begin
    rptFire = rptFirst_q ? (rptCnt_q == RPT_PER) : (rptCnt_q == RPT_DLY);
  end
`endif

  // Press arbitration FSM with registered one-cycle Up_o/Dn_o/Blocked_o pulses.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      Up_o      <= 1'b0;
      Dn_o      <= 1'b0;
      Blocked_o <= 1'b0;
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
      rptCnt_q   <= '0;
      rptFirst_q <= 1'b0;
      rptMute_q  <= 1'b0;
`endif
    end else begin
      Up_o      <= 1'b0;
      Dn_o      <= 1'b0;
      Blocked_o <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
          rptCnt_q   <= '0;
          rptFirst_q <= 1'b0;
          rptMute_q  <= 1'b0;
`endif
          if (press[1] && press[0]) begin
            state_q <= LOCK;
          end else if (press[1]) begin
            state_q <= HOLD_UP;
            if (atMax) begin
              Blocked_o <= 1'b1;
            end else begin
              Up_o <= 1'b1;
            end
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
            rptCnt_q  <= RPT_W'(1);
            rptMute_q <= atMax;
`endif
          end else if (press[0]) begin
            state_q <= HOLD_DN;
            if (atMin) begin
              Blocked_o <= 1'b1;
            end else begin
              Dn_o <= 1'b1;
            end
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
            rptCnt_q  <= RPT_W'(1);
            rptMute_q <= atMin;
`endif
          end
        end

        HOLD_UP: begin
          if (debLvl_q[1]) begin
            state_q <= IDLE;
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
            rptCnt_q   <= '0;
            rptFirst_q <= 1'b0;
            rptMute_q  <= 1'b0;
`endif
          end else if (!debLvl_q[0]) begin
            state_q <= LOCK;
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
            rptCnt_q   <= '0;
            rptFirst_q <= 1'b0;
            rptMute_q  <= 1'b0;
`endif
          end else begin
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
            if (!rptMute_q) begin
              if (rptFire) begin
                rptCnt_q   <= RPT_W'(1);
                rptFirst_q <= 1'b1;
                if (atMax) begin
                  Blocked_o <= 1'b1;
                  rptMute_q <= 1'b1;
                end else begin
                  Up_o <= 1'b1;
                end
              end else begin
                rptCnt_q <= rptCnt_q + RPT_W'(1);
              end
            end
`else
            state_q <= HOLD_UP;
`endif
          end
        end

        HOLD_DN: begin
          if (debLvl_q[0]) begin
            state_q <= IDLE;
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
            rptCnt_q   <= '0;
            rptFirst_q <= 1'b0;
            rptMute_q  <= 1'b0;
`endif
          end else if (!debLvl_q[1]) begin
            state_q <= LOCK;
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
            rptCnt_q   <= '0;
            rptFirst_q <= 1'b0;
            rptMute_q  <= 1'b0;
`endif
          end else begin
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
            if (!rptMute_q) begin
              if (rptFire) begin
                rptCnt_q   <= RPT_W'(1);
                rptFirst_q <= 1'b1;
                if (atMin) begin
                  Blocked_o <= 1'b1;
                  rptMute_q <= 1'b1;
                end else begin
                  Dn_o <= 1'b1;
                end
              end else begin
                rptCnt_q <= rptCnt_q + RPT_W'(1);
              end
            end
`else
            state_q <= HOLD_DN;
`endif
          end
        end

        LOCK: begin
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
          rptCnt_q   <= '0;
          rptFirst_q <= 1'b0;
          rptMute_q  <= 1'b0;
`endif
          if (debLvl_q == 2'b11) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign State_o = state_q;

endmodule

// File: tb/tb_counter_push_ctrl.sv
// tb_counter_push_ctrl
// Directed bench for counter_push_ctrl (DEB_CYCLES=4). Inputs change on the
// falling edge; outputs are sampled 1 time unit after each rising edge.
// Edge numbers in a watch window start at 1 for the first rising edge after
// the inputs were applied. Build with COUNTER_PUSH_CTRL_AUTOREPEAT_EN to
// check the auto-repeat timing instead of the single-pulse behaviour.

module tb_counter_push_ctrl;

  logic       clock;
  logic       reset;
  logic [1:0] push;
  logic [3:0] cnt;
  logic       upO;
  logic       dnO;
  logic       blockedO;
  logic [1:0] stateO;

  int testsRun;
  int testsFailed;

  int upCnt;
  int dnCnt;
  int blkCnt;
  int upFirst;
  int dnFirst;
  int blkFirst;
  int hitFirst;
  int offTarget;
  int exclErr;
  int upEdges[$];

  counter_push_ctrl dut (
    .Clk       (clock),
    .Rst       (reset),
    .Push      (push),
    .Cnt_i     (cnt),
    .Up_o      (upO),
    .Dn_o      (dnO),
    .Blocked_o (blockedO),
    .State_o   (stateO)
  );

  // 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives buttons and the fed-back counter value (called on a falling edge).
  task automatic applyStimulus(input logic [1:0] p, input logic [3:0] c);
    push = p;
    cnt  = c;
  endtask

  // Runs n rising edges, recording pulses and when State_o first equals target.
  task automatic runWatch(input int n, input logic [1:0] target);
    upCnt = 0; dnCnt = 0; blkCnt = 0;
    upFirst = 0; dnFirst = 0; blkFirst = 0;
    hitFirst = 0; offTarget = 0; exclErr = 0;
    upEdges.delete();
    for (int k = 1; k <= n; k++) begin
      @(posedge clock);
      #1;
      if (upO === 1'b1) begin
        upCnt++;
        if (upFirst == 0) upFirst = k;
        upEdges.push_back(k);
      end
      if (dnO === 1'b1) begin
        dnCnt++;
        if (dnFirst == 0) dnFirst = k;
      end
      if (blockedO === 1'b1) begin
        blkCnt++;
        if (blkFirst == 0) blkFirst = k;
      end
      if (stateO === target) begin
        if (hitFirst == 0) hitFirst = k;
      end else begin
        offTarget++;
      end
      if ((int'(upO) + int'(dnO) + int'(blockedO)) > 1) exclErr++;
      @(negedge clock);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset = 1'b1;
    applyStimulus(2'b11, 4'd3);

    // Reset for two edges, then release.
    @(negedge clock);
    runWatch(2, 2'd0);
    checkOutput("rst up", upO, 0);
    checkOutput("rst dn", dnO, 0);
    checkOutput("rst blk", blockedO, 0);
    checkOutput("rst state", stateO, 0);
    reset = 1'b0;
    runWatch(4, 2'd0);
    checkOutput("post-rst idle", offTarget + upCnt + dnCnt + blkCnt, 0);

    // Up press with Cnt=3: one Up_o at edge 7, then release returns to IDLE at edge 7.
    applyStimulus(2'b01, 4'd3);
    runWatch(10, 2'd1);
    checkOutput("up count", upCnt, 1);
    checkOutput("up edge", upFirst, 7);
    checkOutput("up state edge", hitFirst, 7);
    checkOutput("up no dn/blk", dnCnt + blkCnt, 0);
    applyStimulus(2'b11, 4'd3);
    runWatch(10, 2'd0);
    checkOutput("release idle edge", hitFirst, 7);
    checkOutput("release no pulse", upCnt + dnCnt + blkCnt, 0);

    // 3-cycle glitch on down is rejected.
    applyStimulus(2'b10, 4'd3);
    runWatch(3, 2'd0);
    applyStimulus(2'b11, 4'd3);
    runWatch(12, 2'd0);
    checkOutput("glitch3 no pulse", upCnt + dnCnt + blkCnt, 0);
    checkOutput("glitch3 state", offTarget, 0);

    // 4-cycle down press is just long enough: Dn_o at edge 7 overall (3rd of window 2).
    applyStimulus(2'b10, 4'd3);
    runWatch(4, 2'd0);
    checkOutput("deb4 early", dnCnt, 0);
    applyStimulus(2'b11, 4'd3);
    runWatch(12, 2'd2);
    checkOutput("deb4 dn count", dnCnt, 1);
    checkOutput("deb4 dn edge", dnFirst, 3);
    checkOutput("deb4 hold edge", hitFirst, 3);
    checkOutput("deb4 final state", stateO, 0);

    // Up at upper limit is blocked.
    applyStimulus(2'b01, 4'd15);
    runWatch(10, 2'd1);
    checkOutput("max blk count", blkCnt, 1);
    checkOutput("max blk edge", blkFirst, 7);
    checkOutput("max no up", upCnt, 0);
    applyStimulus(2'b11, 4'd15);
    runWatch(10, 2'd0);

    // Down at lower limit is blocked.
    applyStimulus(2'b10, 4'd0);
    runWatch(10, 2'd2);
    checkOutput("min blk count", blkCnt, 1);
    checkOutput("min no dn", dnCnt, 0);
    applyStimulus(2'b11, 4'd0);
    runWatch(10, 2'd0);

    // Up at lower limit is allowed.
    applyStimulus(2'b01, 4'd0);
    runWatch(10, 2'd1);
    checkOutput("min up count", upCnt, 1);
    checkOutput("min up no blk", blkCnt, 0);
    applyStimulus(2'b11, 4'd0);
    runWatch(10, 2'd0);

    // Simultaneous press locks; partial release stays locked.
    applyStimulus(2'b00, 4'd7);
    runWatch(10, 2'd3);
    checkOutput("lock edge", hitFirst, 7);
    checkOutput("lock no pulse", upCnt + dnCnt + blkCnt, 0);
    applyStimulus(2'b10, 4'd7);
    runWatch(10, 2'd3);
    checkOutput("lock partial state", offTarget, 0);
    checkOutput("lock partial no pulse", upCnt + dnCnt + blkCnt, 0);
    applyStimulus(2'b11, 4'd7);
    runWatch(10, 2'd0);
    checkOutput("unlock edge", hitFirst, 7);
    checkOutput("unlock no pulse", upCnt + dnCnt + blkCnt, 0);

    // Long hold at the limit: a single Blocked_o, never Up_o.
    applyStimulus(2'b01, 4'd15);
    runWatch(30, 2'd1);
    checkOutput("hold max blk", blkCnt, 1);
    checkOutput("hold max up", upCnt, 0);
    applyStimulus(2'b11, 4'd15);
    runWatch(10, 2'd0);

    // Long hold with Cnt=5.
    applyStimulus(2'b01, 4'd5);
    runWatch(40, 2'd1);
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
    checkOutput("rpt count", upCnt, 4);
    checkOutput("rpt e0", (upEdges.size() > 0) ? upEdges[0] : 0, 7);
    checkOutput("rpt e1", (upEdges.size() > 1) ? upEdges[1] : 0, 23);
    checkOutput("rpt e2", (upEdges.size() > 2) ? upEdges[2] : 0, 31);
    checkOutput("rpt e3", (upEdges.size() > 3) ? upEdges[3] : 0, 39);
`else
    checkOutput("hold single up", upCnt, 1);
    checkOutput("hold up edge", upFirst, 7);
`endif
    checkOutput("hold excl", exclErr, 0);
    applyStimulus(2'b11, 4'd5);
    runWatch(10, 2'd0);

    // Reset at t0+20 while holding: no pulse at t0+24, then one fresh press.
    applyStimulus(2'b01, 4'd5);
    runWatch(26, 2'd1);
    checkOutput("rsthold first edge", upFirst, 7);
`ifdef COUNTER_PUSH_CTRL_AUTOREPEAT_EN
    checkOutput("rsthold pre count", upCnt, 2);
`else
    checkOutput("rsthold pre count", upCnt, 1);
`endif
    reset = 1'b1;
    runWatch(1, 2'd0);
    checkOutput("rsthold state", hitFirst, 1);
    checkOutput("rsthold rst pulse", upCnt + dnCnt + blkCnt, 0);
    reset = 1'b0;
    runWatch(5, 2'd0);
    checkOutput("rsthold quiet", upCnt + dnCnt + blkCnt, 0);
    checkOutput("rsthold quiet state", offTarget, 0);
    runWatch(3, 2'd1);
    checkOutput("rsthold fresh count", upCnt, 1);
    checkOutput("rsthold fresh edge", upFirst, 2);
    checkOutput("rsthold fresh state", hitFirst, 2);
    applyStimulus(2'b11, 4'd5);
    runWatch(10, 2'd0);
    checkOutput("final idle", stateO, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/counter_push_ctrl.md
Name: counter_push_ctrl

Overview:
- Front-end controller for the 4-bit LED up/down counter.
- Takes the two raw active-low push buttons, then synchronises, debounces and edge-detects them.
- Arbitrates simultaneous presses and enforces count limits using the counter's current value.
- Issues single-cycle Up_o/Dn_o enables to the counter datapath; the counter itself only applies them.

Parameters:
- CNT_W, 4, width of counter value fed back on Cnt_i
- CNT_MAX, 15, upper limit; Up_o suppressed when Cnt_i == CNT_MAX
- CNT_MIN, 0, lower limit; Dn_o suppressed when Cnt_i == CNT_MIN
- DEB_CYCLES, 4, consecutive stable cycles required to accept a button level change (>=2)
- RPT_DELAY, 16, hold cycles before first auto-repeat (optional feature only)
- RPT_RATE, 8, cycles between subsequent auto-repeats (optional feature only)

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  synchronous reset, active-high
- Push  in  2  raw buttons, active-low; Push[1] = up, Push[0] = down; 2'b11 = idle
- Cnt_i  in  CNT_W  current counter value
- Up_o  out  1  one-cycle increment enable
- Dn_o  out  1  one-cycle decrement enable
- Blocked_o  out  1  one-cycle pulse when an accepted press is rejected at a limit
- State_o  out  2  FSM state: 0 IDLE, 1 HOLD_UP, 2 HOLD_DN, 3 LOCK

Behaviour:
- Reset (Rst high at a rising edge):
  - Synchroniser and debounced levels := 2'b11; debounce counters := 0.
  - FSM := IDLE; Up_o, Dn_o, Blocked_o := 0; State_o := 0.
  - Reset mid-hold: no pulse is emitted. After Rst drops, a still-held button first debounces from the released state, so it produces one fresh press.
- Synchroniser: 2 flops per bit.
- Debounce, per bit:
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments.
  - When the level has differed for DEB_CYCLES consecutive cycles, the debounced level updates and the counter clears.
  - Glitches shorter than DEB_CYCLES produce no change.
- Press event: falling edge of a debounced bit, detected with a registered previous value.
- Latency: a clean Push transition first sampled at edge N gives its output pulse high after edge N+DEB_CYCLES+2, for exactly one cycle. All outputs are registered.
- FSM:
  - IDLE:
    - Both debounced low in the same cycle (simultaneous press) -> LOCK, no pulse.
    - Up press only -> HOLD_UP, with one Up_o pulse (or one Blocked_o pulse if Cnt_i == CNT_MAX).
    - Down press only -> HOLD_DN, with one Dn_o pulse (or Blocked_o if Cnt_i == CNT_MIN).
  - HOLD_UP:
    - Up debounced high -> IDLE.
    - Down debounced low -> LOCK, no pulse.
    - Otherwise stay.
  - HOLD_DN: mirror of HOLD_UP.
  - LOCK: stay until both debounced high -> IDLE. No pulses in LOCK.
- Mutual exclusion: Up_o, Dn_o and Blocked_o are never high together.
- Limit check: uses Cnt_i sampled in the same cycle the pulse decision is made.
- Counter contract: the counter applies an Up_o/Dn_o pulse at the next rising edge, so Cnt_i reflects it one cycle after the pulse.

Optional Feature:
- Macro: COUNTER_PUSH_CTRL_AUTOREPEAT_EN.
- Defined:
  - In HOLD_UP/HOLD_DN a repeat counter starts at the initial pulse.
  - A repeat pulse fires after RPT_DELAY cycles, then every RPT_RATE cycles while the button is held.
  - Each repeat obeys the limit check: at the limit it emits Blocked_o once, then stays silent until release.
  - The repeat counter clears on leaving the state and on Rst.
- Undefined: exactly one pulse per press; no repeat counter logic present.

Test Plan (DEB_CYCLES=4; stimulus changes on negedge Clk):
1. Rst=1 for 2 cycles with Push=2'b11, then Rst=0 -> all outputs 0, State_o=0.
2. Push 2'b11->2'b01 held 10 cycles with Cnt_i=3 -> exactly one Up_o pulse, 7th rising edge after change, State_o=1. Release -> State_o=0 after DEB_CYCLES+3 edges, no pulse.
3. Push=2'b10 pulse of 3 cycles, then 2'b11 -> no output, State_o stays 0.
4. Cnt_i=15, press up -> Blocked_o one cycle, no Up_o. Cnt_i=0, press down -> Blocked_o, no Dn_o. Cnt_i=0, press up -> Up_o.
5. Push 2'b11->2'b00 -> State_o=3, no pulses. Release up only (2'b10) -> still 3, no Dn_o. Then 2'b11 -> State_o=0.
6. Macro defined, RPT_DELAY=16, RPT_RATE=8, Cnt_i=5 held: hold up 40 cycles -> Up_o at t0, t0+16, t0+24, t0+32. Rst asserted at t0+20 -> no pulse at t0+24, State_o=0.
